uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_fifo_ram.sv | 39 +++
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: status counter width and saturating increment helper.
package uart_pkg;

  localparam int STAT_W = 8;

  typedef logic [STAT_W-1:0] stat_t;

  function automatic stat_t sat_inc(input stat_t v);
    return (v == {STAT_W{1'b1}}) ? v : v + stat_t'(1);
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address write is forwarded so a freshly written head is visible next cycle.
module uart_fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; the array itself keeps its content.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata_reg <= wdata;
    end else begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: parity filtering, overflow drop,
// first-word-fall-through head and saturating error statistics.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 16,
  parameter int DROP_BAD_PARITY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_pc_pass,
  output logic                       in_rdy,
  output logic                       m_vld,
  output logic [DATA_WIDTH-1:0]      m_data,
  input  logic                       m_rdy,
  input  logic                       flush,
  input  logic                       clr_stat,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic [STAT_W-1:0]          ovf_cnt,
  output logic [STAT_W-1:0]          perr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end
  if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
    $fatal(1, "uart_rx_fifo: DATA_WIDTH must be in 2..8");
  end

  logic [1:0]    sync_reg;
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          m_vld_reg, full_reg, empty_reg;
  logic          full_next, empty_next;
  stat_t         ovf_reg, perr_reg;

  logic accept, parity_bad, storable, pop, wr_en, ovf_hit;

  // Reset asserts immediately but releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign in_rdy = sync_reg[1];

  always_comb begin
    accept      = in_vld && in_rdy && !flush;
    parity_bad  = accept && !in_pc_pass;
    storable    = accept && (in_pc_pass || (DROP_BAD_PARITY == 0));
    pop         = m_vld_reg && m_rdy && !flush;
    wr_en       = storable && (!full_reg || pop);
    ovf_hit     = storable && full_reg && !pop;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_en};
      rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
      level_next  = level_reg + {{(LW-1){1'b0}}, wr_en} - {{(LW-1){1'b0}}, pop};
    end
    // Extra pointer bit differs only when the write pointer has lapped the read pointer.
    empty_next = (wr_ptr_next == rd_ptr_next);
    full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                 (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      m_vld_reg  <= 1'b0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      m_vld_reg  <= !empty_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg  <= '0;
      perr_reg <= '0;
    end else if (clr_stat) begin
      ovf_reg  <= '0;
      perr_reg <= '0;
    end else begin
      if (ovf_hit) begin
        ovf_reg <= sat_inc(ovf_reg);
      end
      if (parity_bad) begin
        perr_reg <= sat_inc(perr_reg);
      end
    end
  end

  // Read address follows the next head so the registered read lands with the pointer update.
  uart_fifo_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_next[AW-1:0]),
    .rdata (m_data)
  );

  assign m_vld    = m_vld_reg;
  assign level    = level_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign ovf_cnt  = ovf_reg;
  assign perr_cnt = perr_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected characters,
// a negedge monitor pops and compares on every accepted pop.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_vld = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_pc_pass = 1'b1;
  logic       m_rdy = 1'b0;
  logic       flush = 1'b0;
  logic       clr_stat = 1'b0;

  logic       in_rdy, m_vld, full, empty;
  logic [7:0] m_data, ovf_cnt, perr_cnt;
  logic [4:0] level;

  logic       in_rdy0, m_vld0, full0, empty0;
  logic [7:0] m_data0, ovf_cnt0, perr_cnt0;
  logic [4:0] level0;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DROP_BAD_PARITY(1)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_pc_pass(in_pc_pass),
    .in_rdy(in_rdy), .m_vld(m_vld), .m_data(m_data), .m_rdy(m_rdy), .flush(flush),
    .clr_stat(clr_stat), .level(level), .full(full), .empty(empty),
    .ovf_cnt(ovf_cnt), .perr_cnt(perr_cnt)
  );

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DROP_BAD_PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_pc_pass(in_pc_pass),
    .in_rdy(in_rdy0), .m_vld(m_vld0), .m_data(m_data0), .m_rdy(m_rdy), .flush(flush),
    .clr_stat(clr_stat), .level(level0), .full(full0), .empty(empty0),
    .ovf_cnt(ovf_cnt0), .perr_cnt(perr_cnt0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pc, input bit stored);
    in_vld     = 1'b1;
    in_data    = d;
    in_pc_pass = pc;
    if (stored) sb.push_back(d);
    tick();
    in_vld     = 1'b0;
    in_pc_pass = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
  endtask

  // Monitor: a pop happens at the coming edge when head valid, consumer ready, no flush.
  always @(negedge clk) begin
    if (rst && m_vld && m_rdy && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        $display("pop  data=0x%02h expected=0x%02h", m_data, sb[0]);
        chk("pop_data", {24'd0, m_data}, {24'd0, sb[0]});
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    tick();
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("rst_m_vld",  {31'd0, m_vld},  32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_level",  {27'd0, level},  32'd0);
    chk("rst_empty",  {31'd0, empty},  32'd1);
    chk("rst_full",   {31'd0, full},   32'd0);
    chk("rst_ovf",    {24'd0, ovf_cnt},  32'd0);
    chk("rst_perr",   {24'd0, perr_cnt}, 32'd0);
    rst = 1'b1;
    tick();
    chk("in_rdy_after_1", {31'd0, in_rdy}, 32'd0);
    tick();
    chk("in_rdy_after_2", {31'd0, in_rdy}, 32'd1);

    // Three characters streamed through with the consumer ready
    m_rdy = 1'b1;
    send(8'h41, 1'b1, 1'b1);
    chk("fwft_vld",  {31'd0, m_vld},  32'd1);
    chk("fwft_data", {24'd0, m_data}, 32'h41);
    send(8'h42, 1'b1, 1'b1);
    send(8'h43, 1'b1, 1'b1);
    repeat (3) tick();
    chk("stream_empty", {31'd0, empty}, 32'd1);
    chk("stream_sb_drained", sb.size(), 32'd0);

    // Twenty characters into a 16-deep FIFO with no consumer
    m_rdy = 1'b0;
    for (int i = 0; i < 20; i++) send(8'h10 + 8'(i), 1'b1, i < 16);
    chk("fill_level", {27'd0, level}, 32'd16);
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_ovf",   {24'd0, ovf_cnt}, 32'd4);
    chk("fill_head",  {24'd0, m_data},  32'h10);

    // Write and pop in the same cycle while full
    m_rdy = 1'b1;
    send(8'h55, 1'b1, 1'b1);
    m_rdy = 1'b0;
    chk("full_wp_level", {27'd0, level}, 32'd16);
    chk("full_wp_full",  {31'd0, full},  32'd1);
    chk("full_wp_ovf",   {24'd0, ovf_cnt}, 32'd4);
    m_rdy = 1'b1;
    for (int i = 0; i < 40 && !empty; i++) tick();
    m_rdy = 1'b0;
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_sb", sb.size(), 32'd0);

    // Parity failure: dropped here, stored by the keep-bad-parity instance
    pulse_clr();
    chk("clr_ovf", {24'd0, ovf_cnt}, 32'd0);
    send(8'h7E, 1'b0, 1'b0);
    chk("drop_level", {27'd0, level}, 32'd0);
    chk("drop_vld",   {31'd0, m_vld}, 32'd0);
    chk("drop_perr",  {24'd0, perr_cnt}, 32'd1);
    chk("keep_level", {27'd0, level0}, 32'd1);
    chk("keep_data",  {24'd0, m_data0}, 32'h7E);
    chk("keep_perr",  {24'd0, perr_cnt0}, 32'd1);

    // Saturation of the parity counter, then clear
    for (int i = 0; i < 300; i++) send(8'h00, 1'b0, 1'b0);
    chk("perr_sat", {24'd0, perr_cnt}, 32'd255);
    chk("perr_sat_level", {27'd0, level}, 32'd0);
    pulse_clr();
    chk("perr_clr", {24'd0, perr_cnt}, 32'd0);

    // Flush together with a write
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b1, 1'b1);
    chk("pre_flush_level", {27'd0, level}, 32'd5);
    flush = 1'b1;
    send(8'h99, 1'b1, 1'b0);
    flush = 1'b0;
    sb.delete();
    chk("flush_level", {27'd0, level}, 32'd0);
    chk("flush_vld",   {31'd0, m_vld}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_ovf",   {24'd0, ovf_cnt}, 32'd0);
    m_rdy = 1'b1;
    repeat (3) tick();
    chk("flush_nothing_left", {31'd0, m_vld}, 32'd0);
    send(8'h3C, 1'b1, 1'b1);
    chk("post_flush_head", {24'd0, m_data}, 32'h3C);
    repeat (3) tick();
    chk("post_flush_sb", sb.size(), 32'd0);

    // Reset asserted mid-operation
    m_rdy = 1'b0;
    send(8'h61, 1'b1, 1'b1);
    send(8'h62, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    sb.delete();
    chk("midrst_vld",    {31'd0, m_vld},  32'd0);
    chk("midrst_level",  {27'd0, level},  32'd0);
    chk("midrst_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("midrst_empty",  {31'd0, empty},  32'd1);
    chk("midrst_data",   {24'd0, m_data}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
